// File: rtl/fir_out_pkg.sv
// Shared defaults and requantization constants for the FIR output decimator.
package fir_out_pkg;

    localparam int unsigned DEF_IN_WL      = 20;
    localparam int unsigned DEF_OUT_WL     = 16;
    localparam int unsigned DEF_FRAC_SHIFT = 4;
    localparam int unsigned DEF_DEC_M      = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    localparam logic [DEF_IN_WL:0]    ROUND_K = (DEF_IN_WL + 1)'(1) << (DEF_FRAC_SHIFT - 1);
    localparam logic [DEF_OUT_WL-1:0] OUT_MAX = {1'b0, {(DEF_OUT_WL - 1){1'b1}}};
    localparam logic [DEF_OUT_WL-1:0] OUT_MIN = {1'b1, {(DEF_OUT_WL - 1){1'b0}}};

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word; level counts the
// head register plus the backing memory.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop, full, wr_en, load;

    // A full FIFO still accepts a write when the head is popped on the same edge.
    always_comb begin
        pop      = valid_q && ready_i;
        full     = (level_q == LW'(DEPTH));
        wr_en    = push_i && (!full || pop);
        load     = (!valid_q || pop) && (cnt_q != '0);
        drop_c   = push_i && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = load  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + LW'(wr_en) - LW'(load);
        level_d  = level_q + LW'(wr_en) - LW'(pop);
        valid_d  = load || (valid_q && !pop);
        data_d   = load ? mem_q[rd_ptr_q] : data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule

// File: rtl/fir_out_decim.sv
// FIR output decimator: keep 1-in-DEC_M samples, round/saturate to OUT_WL, buffer in a FIFO.
// Define DEC_STATS_EN to build the saturation event counter behind sat_count.
module fir_out_decim
    import fir_out_pkg::*;
#(
    parameter int unsigned IN_WL      = DEF_IN_WL,
    parameter int unsigned OUT_WL     = DEF_OUT_WL,
    parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int unsigned DEC_M      = DEF_DEC_M,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [IN_WL-1:0]              in_data,
    input  logic                          phase_sync,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WL-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_ovf,
    output logic [15:0]                   sat_count
);

    localparam int unsigned PW = (DEC_M > 1) ? $clog2(DEC_M) : 1;
    localparam int unsigned TW = IN_WL + 1;
    localparam int unsigned QW = TW - FRAC_SHIFT;

    localparam logic [TW-1:0]     RND_K  = TW'(1) << (FRAC_SHIFT - 1);
    localparam logic [OUT_WL-1:0] SAT_HI = {1'b0, {(OUT_WL - 1){1'b1}}};
    localparam logic [OUT_WL-1:0] SAT_LO = {1'b1, {(OUT_WL - 1){1'b0}}};

    logic [PW-1:0]     phase_q, phase_d;
    logic              keep_c;
    logic              s1_v_q;
    logic [TW-1:0]     s1_t_q, s1_t_d;
    logic              s2_v_q;
    logic [OUT_WL-1:0] s2_d_q, s2_d_d;
    logic [QW-1:0]     q_c;
    logic              sat_c;
    logic              overflow_q, overflow_d;
    logic              drop_c;

    // Phase only advances on valid input; phase_sync forces a keep and restarts the count.
    always_comb begin
        phase_d = phase_q;
        keep_c  = 1'b0;
        if (in_valid) begin
            keep_c = phase_sync || (phase_q == '0);
            if (phase_sync) begin
                phase_d = (DEC_M == 1) ? '0 : PW'(1);
            end else if (phase_q == PW'(DEC_M - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end else if (phase_sync) begin
            phase_d = '0;
        end
    end

    // Round half up in one extra bit, then take the arithmetic-shifted field and clamp.
    always_comb begin
        s1_t_d = {in_data[IN_WL-1], in_data} + RND_K;
        q_c    = s1_t_q[TW-1:FRAC_SHIFT];
        sat_c  = (q_c[QW-1:OUT_WL-1] != {(QW - OUT_WL + 1){q_c[QW-1]}});
        s2_d_d = sat_c ? (q_c[QW-1] ? SAT_LO : SAT_HI) : q_c[OUT_WL-1:0];
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            s1_v_q     <= 1'b0;
            s1_t_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_d_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_v_q     <= keep_c;
            s1_t_q     <= s1_t_d;
            s2_v_q     <= s1_v_q;
            s2_d_q     <= s2_d_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s2_v_q),
        .data_i  (s2_d_q),
        .ready_i (out_ready),
        .data_o  (out_data),
        .valid_o (out_valid),
        .level_o (fifo_level),
        .drop_c  (drop_c)
    );

    assign overflow = overflow_q;

`ifdef DEC_STATS_EN
    logic        s2_sat_q;
    logic [15:0] satc_q, satc_d;

    // Counts clamps of kept samples; an increment coinciding with a clear restarts at 1.
    always_comb begin
        satc_d = satc_q;
        if (s2_v_q && s2_sat_q) begin
            if (clear_ovf) begin
                satc_d = 16'd1;
            end else if (satc_q != 16'hFFFF) begin
                satc_d = satc_q + 16'd1;
            end
        end else if (clear_ovf) begin
            satc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sat_q <= 1'b0;
            satc_q   <= '0;
        end else begin
            s2_sat_q <= s1_v_q && sat_c;
            satc_q   <= satc_d;
        end
    end

    assign sat_count = satc_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: one DUT with DEC_M=1, one with DEC_M=4, shared stimulus.
module tb_fir_out_decim;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data;
    logic        phase_sync;
    logic        out_ready;
    logic        clear_ovf;

    logic        ov1, ov4;
    logic [15:0] od1, od4;
    logic [3:0]  lvl1, lvl4;
    logic        ovf1, ovf4;
    logic [15:0] sc1, sc4;

    int total = 0;
    int bad   = 0;
    int got[$];

    always #5 clk = ~clk;

    fir_out_decim #(.DEC_M(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .phase_sync(phase_sync), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .fifo_level(lvl1), .overflow(ovf1),
        .clear_ovf(clear_ovf), .sat_count(sc1)
    );

    fir_out_decim #(.DEC_M(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .phase_sync(phase_sync), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .fifo_level(lvl4), .overflow(ovf4),
        .clear_ovf(clear_ovf), .sat_count(sc4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Record the DEC_M=4 head word if it is handshaken on the coming edge, then advance.
    task automatic step_c();
        if (ov4 && out_ready) got.push_back(int'($signed(od4)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; phase_sync = 1'b0;
        out_ready = 1'b0; clear_ovf = 1'b0;
        cyc();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ov1 !== 1'b0)     begin bad++; $display("FAIL rst_valid got=%0b want=0", ov1); end
        total++; if (od1 !== 16'h0)    begin bad++; $display("FAIL rst_data got=%h want=0000", od1); end
        total++; if (lvl1 !== 4'd0)    begin bad++; $display("FAIL rst_level got=%0d want=0", lvl1); end
        total++; if (ovf1 !== 1'b0)    begin bad++; $display("FAIL rst_ovf got=%0b want=0", ovf1); end
        total++; if (sc1 !== 16'h0)    begin bad++; $display("FAIL rst_satcnt got=%0d want=0", sc1); end
    endtask

    task automatic test_rounding();
        int vin[4]  = '{24, -25, 8, -8};
        int vexp[4] = '{2, -2, 1, 0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 20'(vin[i]);
            cyc();
            in_valid = 1'b0;
            cyc();
            cyc();
            total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL round_early[%0d] valid=%0b want=0", i, ov1); end
            cyc();
            total++;
            if (ov1 !== 1'b1 || int'($signed(od1)) != vexp[i]) begin
                bad++; $display("FAIL round[%0d] valid=%0b data=%0d want=%0d", i, ov1, $signed(od1), vexp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 20'h7FFFF;
        cyc();
        in_data = 20'h80000;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        total++; if (ov1 !== 1'b1 || od1 !== 16'h7FFF) begin bad++; $display("FAIL sat_pos valid=%0b data=%h want=7fff", ov1, od1); end
        cyc();
        total++; if (ov1 !== 1'b1 || od1 !== 16'h8000) begin bad++; $display("FAIL sat_neg valid=%0b data=%h want=8000", ov1, od1); end
`ifdef DEC_STATS_EN
        total++; if (sc1 !== 16'd1) begin bad++; $display("FAIL sat_count got=%0d want=1", sc1); end
`else
        total++; if (sc1 !== 16'd0) begin bad++; $display("FAIL sat_count got=%0d want=0", sc1); end
`endif
    endtask

    task automatic test_decimation();
        int e1[4] = '{0, 4, 8, 12};
        int e2[5] = '{0, 4, 6, 10, 14};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * n);
            step_c();
        end
        in_valid = 1'b0;
        repeat (8) step_c();
        total++; if (got.size() != 4) begin bad++; $display("FAIL dec_count got=%0d want=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got.size() || got[i] != e1[i]) begin
                bad++; $display("FAIL dec[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i] : -999, e1[i]);
            end
        end

        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * n); phase_sync = (n == 6);
            step_c();
        end
        in_valid = 1'b0; phase_sync = 1'b0;
        repeat (8) step_c();
        total++; if (got.size() != 5) begin bad++; $display("FAIL sync_count got=%0d want=5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= got.size() || got[i] != e2[i]) begin
                bad++; $display("FAIL sync[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i] : -999, e2[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * n);
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        total++; if (lvl4 !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d want=8", lvl4); end
        total++; if (ovf4 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", ovf4); end
        out_ready = 1'b1;
        repeat (12) step_c();
        total++; if (got.size() != 8) begin bad++; $display("FAIL drain_count got=%0d want=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= got.size() || got[i] != 4 * i) begin
                bad++; $display("FAIL drain[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i] : -999, 4 * i);
            end
        end
        total++; if (lvl4 !== 4'd0) begin bad++; $display("FAIL drain_level got=%0d want=0", lvl4); end
        total++; if (ovf4 !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", ovf4); end
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", ovf4); end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int n = 0; n < 32; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * n);
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        total++; if (lvl4 !== 4'd8 || ovf4 !== 1'b0) begin bad++; $display("FAIL full_pre level=%0d ovf=%0b want=8/0", lvl4, ovf4); end
        in_valid = 1'b1; in_data = 20'(16 * 32);
        cyc();
        in_valid = 1'b0;
        cyc();
        total++; if (ov4 !== 1'b1 || od4 !== 16'd0) begin bad++; $display("FAIL full_head valid=%0b data=%0d want=1/0", ov4, od4); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (lvl4 !== 4'd8) begin bad++; $display("FAIL full_rw_level got=%0d want=8", lvl4); end
        total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL full_rw_ovf got=%0b want=0", ovf4); end
        total++; if (od4 !== 16'd4) begin bad++; $display("FAIL full_rw_next got=%0d want=4", od4); end
        out_ready = 1'b1;
        repeat (12) step_c();
        total++; if (got.size() != 8) begin bad++; $display("FAIL full_drain_count got=%0d want=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= got.size() || got[i] != 4 * (i + 1)) begin
                bad++; $display("FAIL full_drain[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i] : -999, 4 * (i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; phase_sync = 1'b1; in_data = 20'(16 * (50 + k));
            cyc();
        end
        in_valid = 1'b0; phase_sync = 1'b0;
        total++; if (lvl4 !== 4'd5) begin bad++; $display("FAIL mid_pre_level got=%0d want=5", lvl4); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++; if (ov4 !== 1'b0)  begin bad++; $display("FAIL mid_rst_valid got=%0b want=0", ov4); end
        total++; if (lvl4 !== 4'd0) begin bad++; $display("FAIL mid_rst_level got=%0d want=0", lvl4); end
        out_ready = 1'b1;
        got.delete();
        for (int n = 0; n < 8; n++) begin
            in_valid = 1'b1; in_data = 20'(16 * (n + 3));
            step_c();
        end
        in_valid = 1'b0;
        repeat (8) step_c();
        total++; if (got.size() != 2) begin bad++; $display("FAIL mid_count got=%0d want=2", got.size()); end
        total++; if (got.size() < 1 || got[0] != 3) begin bad++; $display("FAIL mid_first got=%0d want=3", (got.size() > 0) ? got[0] : -999); end
        total++; if (got.size() < 2 || got[1] != 7) begin bad++; $display("FAIL mid_second got=%0d want=7", (got.size() > 1) ? got[1] : -999); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; phase_sync = 1'b0;
        out_ready = 1'b0; clear_ovf = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_overflow();
        test_full_rw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
